pes_brg_tx_ctrl: RTL
====================

Name: pes_brg_tx_ctrl

Overview:
- Controller that configures and sequences the baud rate generator (iiitb_brg) and uses its `clkout` as the bit clock for an 8N1 serial transmitter.
- Accepts baud-select change requests and byte-transmit requests over valid/ready handshakes.
- Applies a new `sel` only between frames, with a bounded BRG reset pulse.
- Sits between the host-side byte interface and the BRG/serial pin.

Parameters:
- SETTLE_CYCLES, 4, clk cycles `brg_reset` is held high after a `sel` change (min 1).
- DATA_BITS, 8, payload bits per frame, LSB first.

Ports:
- clk  in  1  system clock, same clock driving the BRG
- reset  in  1  asynchronous, active-high reset
- cfg_sel  in  2  requested baud select
- cfg_valid  in  1  configuration request valid
- cfg_ready  out  1  configuration request accepted this cycle when valid&ready
- tx_data  in  8  byte to transmit
- tx_valid  in  1  byte request valid
- tx_ready  out  1  byte accepted this cycle when valid&ready
- brg_clkout  in  1  BRG output (square wave, synchronous to clk)
- brg_sel  out  2  select driven to BRG
- brg_reset  out  1  reset driven to BRG
- txd  out  1  serial output, idle high
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values (asynchronous): state=IDLE, brg_sel=2'b00, brg_reset=1, txd=1, busy=0, cfg_ready=0, tx_ready=0, settle counter=0, bit counter=0, edge-detect register=0.
- After reset deasserts, the FSM enters RECONF with sel=00. brg_reset stays high for SETTLE_CYCLES cycles, then IDLE.
- Baud tick: `tick = brg_clkout & ~clkout_q`, one clk pulse per BRG period. clkout_q is a registered copy of brg_clkout. tick is forced to 0 while brg_reset=1.
- IDLE: cfg_ready=1 and tx_ready=(~cfg_valid). Ready signals are combinational from state and cfg_valid; they are low in all other states.
- IDLE transitions:
  - cfg_valid=1: latch cfg_sel into brg_sel, assert brg_reset, load the settle counter, go to RECONF. Config has priority when cfg_valid and tx_valid are both high; tx is not accepted that cycle.
  - Otherwise, tx_valid=1: latch tx_data into the shifter, go to SYNC.
- RECONF: brg_reset=1; decrement the settle counter. brg_reset deasserts on the cycle the counter reaches 0, and the FSM returns to IDLE.
- SYNC: wait for tick. On tick, txd<=0 (start bit, visible the cycle after the tick), go to DATA with bit counter=0.
- DATA: on each tick, txd<=shifter[0], shift right, bit counter++. After DATA_BITS data bits have been driven, the next tick drives txd<=1 (stop bit) and moves to STOP.
- STOP: on tick go to IDLE. txd stays 1. Frame length is exactly 10 tick periods from the start-bit edge to the IDLE entry.
- Ticks in IDLE and RECONF are ignored.
- Requests presented while busy are held off (ready=0). Inputs need not be stable after acceptance.
- brg_sel changes only in the IDLE→RECONF transition, never mid-frame.
- Reset mid-frame: txd returns to 1 asynchronously; the partial frame is dropped and not retransmitted.
- Back-to-back frames: after STOP→IDLE, a pending tx_valid is accepted on the next cycle. The next start bit begins at the following tick, so at least one idle-high bit time separates frames.

Decomposition:
- Package pes_brg_pkg:
  - state enum {IDLE, RECONF, SYNC, DATA, STOP}
  - sel encoding constants SEL_0..SEL_3
  - START_BIT=0, STOP_BIT=1
  - default SETTLE_CYCLES
- Sub-module pes_brg_tick_det: rising-edge detector with a gating input (brg_reset) producing tick.

Test Plan:
1. Reset, then release with no requests. Expect:
   - brg_reset high for 4 cycles after release, then low
   - state IDLE, txd=1, busy=0, cfg_ready=1, tx_ready=1
2. Send tx_data=8'hA5 with a BRG model ticking every 16 clk. Expect:
   - txd sequence per tick period: 0,1,0,1,0,0,1,0,1,1
   - busy low after 10 periods
   - tx_ready=0 throughout the frame
3. Raise cfg_valid with cfg_sel=2'b10 and tx_valid (8'h3C) in the same cycle. Expect:
   - config accepted first, tx_ready=0 that cycle
   - brg_sel=10, brg_reset high 4 cycles
   - then the 8'h3C frame sent at the new rate
4. Raise cfg_valid (sel=11) during a frame of 8'hFF. Expect:
   - cfg_ready=0 until the frame ends
   - brg_sel unchanged mid-frame
   - applied immediately after STOP
5. Assert reset at the 4th data bit of 8'h00. Expect:
   - txd=1 asynchronously, brg_reset=1, brg_sel=00
   - no resumption of the frame after release
6. Hold tx_valid high with 8'h01 then 8'h80 back-to-back. Expect:
   - two correct frames
   - at least one idle-high bit time between them

Source files
------------

// File: rtl/pes_brg_pkg.sv
// ---------------------------------------------------------------------------
// pes_brg_pkg
// Shared definitions for the BRG transmit controller:
//   - FSM state codes (plain localparams so older flows can probe them)
//   - baud-select encoding handed to the BRG
//   - line levels for the start and stop bits
//   - default settle time and frame payload width
// ---------------------------------------------------------------------------
package pes_brg_pkg;

  localparam int SETTLE_CYCLES_DEF = 4;
  localparam int DATA_BITS_DEF     = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_RECONF = 3'd1;
  localparam state_t ST_SYNC   = 3'd2;
  localparam state_t ST_DATA   = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  typedef enum logic [1:0] {
    SEL_0 = 2'b00,
    SEL_1 = 2'b01,
    SEL_2 = 2'b10,
    SEL_3 = 2'b11
  } sel_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/pes_brg_tick_det.sv
// ---------------------------------------------------------------------------
// pes_brg_tick_det
// Turns the BRG square wave into a one-clk baud tick on each rising edge.
// Ports:
//   clk, reset : system clock, async active-high reset
//   clkout     : BRG output, already synchronous to clk
//   gate       : while high (BRG held in reset) no tick is produced
//   tick       : one-cycle pulse per BRG period
// ---------------------------------------------------------------------------
module pes_brg_tick_det (
  input  logic clk,
  input  logic reset,
  input  logic clkout,
  input  logic gate,
  output logic tick
);

  logic clkout_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) clkout_q <= 1'b0;
    else       clkout_q <= clkout;
  end

  assign tick = clkout & ~clkout_q & ~gate;

endmodule

// File: rtl/pes_brg_tx_ctrl.sv
// ---------------------------------------------------------------------------
// pes_brg_tx_ctrl
// Programs the baud rate generator and sends 8N1 frames clocked by its ticks.
// Ports:
//   clk, reset           : system clock (shared with BRG), async active-high
//   cfg_sel/valid/ready  : baud-select change request (valid/ready)
//   tx_data/valid/ready  : byte transmit request (valid/ready)
//   brg_clkout           : BRG square wave, synchronous to clk
//   brg_sel, brg_reset   : controls driven to the BRG
//   txd                  : serial line, idles high
//   busy                 : high whenever the FSM is outside IDLE
// A new select is only applied between frames; the BRG is then held in reset
// for SETTLE_CYCLES clocks so it restarts cleanly at the new rate.
// ---------------------------------------------------------------------------
module pes_brg_tx_ctrl
  import pes_brg_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int DATA_BITS     = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           cfg_sel,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 brg_clkout,
  output logic [1:0]           brg_sel,
  output logic                 brg_reset,
  output logic                 txd,
  output logic                 busy
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  state_t               state_q,  state_d;
  logic                 init_q,   init_d;
  sel_e                 sel_q,    sel_d;
  logic                 brg_rst_q, brg_rst_d;
  logic                 txd_q,    txd_d;
  logic [CNT_W-1:0]     settle_q, settle_d;
  logic [BIT_W-1:0]     bit_q,    bit_d;
  logic [DATA_BITS-1:0] shift_q,  shift_d;
  logic                 tick;

  pes_brg_tick_det u_tick_det (
    .clk    (clk),
    .reset  (reset),
    .clkout (brg_clkout),
    .gate   (brg_rst_q),
    .tick   (tick)
  );

  // init_q marks the first IDLE cycle after reset: instead of accepting
  // requests, the FSM first runs one RECONF pass with the reset select.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d   = state_q;
    init_d    = init_q;
    sel_d     = sel_q;
    brg_rst_d = brg_rst_q;
    txd_d     = txd_q;
    settle_d  = settle_q;
    bit_d     = bit_q;
    shift_d   = shift_q;

    case (state_q)
      ST_IDLE: begin
        if (init_q) begin
          init_d    = 1'b0;
          brg_rst_d = 1'b1;
          settle_d  = CNT_W'(SETTLE_CYCLES);
          state_d   = ST_RECONF;
        end else if (cfg_valid) begin
          // Config wins over a simultaneous byte request.
          sel_d     = sel_e'(cfg_sel);
          brg_rst_d = 1'b1;
          settle_d  = CNT_W'(SETTLE_CYCLES);
          state_d   = ST_RECONF;
        end else if (tx_valid) begin
          shift_d = tx_data;
          state_d = ST_SYNC;
        end
      end

      ST_RECONF: begin
        settle_d = settle_q - CNT_W'(1);
        // Release the BRG on the cycle the counter reaches zero.
        if (settle_q <= CNT_W'(1)) begin
          settle_d  = '0;
          brg_rst_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end

      ST_SYNC: begin
        if (tick) begin
          txd_d   = START_BIT;
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (bit_q == BIT_W'(DATA_BITS)) begin
            txd_d   = STOP_BIT;
            state_d = ST_STOP;
          end else begin
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BIT_W'(1);
          end
        end
      end

      ST_STOP: begin
        if (tick) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      init_q    <= 1'b1;
      sel_q     <= SEL_0;
      brg_rst_q <= 1'b1;
      txd_q     <= STOP_BIT;
      settle_q  <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      init_q    <= init_d;
      sel_q     <= sel_d;
      brg_rst_q <= brg_rst_d;
      txd_q     <= txd_d;
      settle_q  <= settle_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
    end
  end

  assign cfg_ready = (state_q == ST_IDLE) & ~init_q;
  assign tx_ready  = cfg_ready & ~cfg_valid;
  assign busy      = (state_q != ST_IDLE);
  assign brg_sel   = sel_q;
  assign brg_reset = brg_rst_q;
  assign txd       = txd_q;

endmodule
